// File: rtl/lsu_pkg.sv
// Shared constants and state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: store strobes/lane replication, access checking,
// and load lane selection with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        chk_we,
  input  logic [1:0]  chk_off,
  input  logic [2:0]  chk_func3,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_lanes,
  output logic [1:0]  chk_err,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_func3,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic        illegal;
  logic        misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_strb  = '0;
    st_lanes = st_data;
    case (chk_func3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << chk_off;
        st_lanes = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << chk_off;
        st_lanes = {2{st_data[15:0]}};
      end
      default: st_strb = 4'b1111;
    endcase
    // Reads never drive byte enables.
    if (!chk_we) st_strb = '0;
  end

  always_comb begin
    if (chk_we) illegal = !(chk_func3 inside {F3_B, F3_H, F3_W});
    else        illegal = !(chk_func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign = ((chk_func3[1:0] == 2'b01) && chk_off[0]) ||
               ((chk_func3[1:0] == 2'b10) && (chk_off != 2'b00));
    if (illegal)       chk_err = ERR_ILLEGAL;
    else if (misalign) chk_err = ERR_MISALIGN;
    else               chk_err = ERR_NONE;
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core access into a handshaked word-aligned memory
// transaction, stalls the pipeline until done, and reports errors/timeouts.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_func3,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [29:0]      waddr_q, waddr_d;
  logic [3:0]       strb_q, strb_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  logic             req_in;
  logic             to_hit;
  logic [3:0]       st_strb;
  logic [31:0]      st_lanes;
  logic [1:0]       chk_err;
  logic [31:0]      ld_data;

  assign req_in = cpu_read || cpu_write;
  assign to_hit = (cnt_q == CNT_LAST);

  lsu_align u_align (
    .chk_we   (cpu_write),
    .chk_off  (cpu_addr[1:0]),
    .chk_func3(cpu_func3),
    .st_data  (cpu_wdata),
    .st_strb  (st_strb),
    .st_lanes (st_lanes),
    .chk_err  (chk_err),
    .ld_off   (off_q),
    .ld_func3 (f3_q),
    .ld_word  (mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_in) begin
          we_d    = cpu_write;
          waddr_d = cpu_addr[31:2];
          strb_d  = st_strb;
          wdata_d = st_lanes;
          off_d   = cpu_addr[1:0];
          f3_d    = cpu_func3;
          rdata_d = '0;
          err_d   = chk_err;
          cnt_d   = '0;
          state_d = (chk_err == ERR_NONE) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        // A completing handshake takes priority over the timeout on the same cycle.
        if (mem_ready && (we_q || mem_rvalid)) begin
          if (!we_q) rdata_d = ld_data;
          state_d = S_DONE;
        end else if (to_hit) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (mem_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = S_DONE;
        end else if (to_hit) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {waddr_q, 2'b00} : '0;
  assign mem_wstrb = mem_req ? strb_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  // Gated by reset so a request held during reset does not show a stall.
  assign cpu_stall = rst && (((state_q == S_IDLE) && req_in) ||
                             (state_q == S_REQ) || (state_q == S_WAIT));
  assign cpu_rdata = (state_q == S_DONE) ? rdata_q : '0;
  assign err_code  = (state_q == S_DONE) ? err_q : ERR_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural memory and access model.
module tb_load_store_unit;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_func3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .err_code(err_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          stall;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } memtx_t;

  resp_t  resp_q[$];
  memtx_t mem_q[$];

  int checks   = 0;
  int failures = 0;

  int          cfg_rdy = 0;
  int          cfg_rv  = 0;
  logic [31:0] cfg_word = '0;

  int mm_rdy_cnt = 0;
  int mm_rv_cnt  = 0;
  bit mm_busy    = 0;
  bit mm_rv_pend = 0;
  int stall_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Access rules: legal sizes, natural alignment, lanes by byte offset.
  function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] f3, input logic [31:0] word,
                                output logic [1:0] err, output logic [31:0] rdata,
                                output logic [3:0] strb, output logic [31:0] wdata);
    int unsigned size;
    int unsigned off;
    logic [31:0] sh;
    bit legal;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 32'd1 << f3[1:0];
    off   = 32'(addr[1:0]);
    if (!legal)              err = 2'd2;
    else if (off % size != 0) err = 2'd1;
    else                     err = 2'd0;
    rdata = '0;
    strb  = '0;
    wdata = '0;
    if (err == 2'd0) begin
      if (wr) begin
        for (int unsigned i = 0; i < 4; i++) begin
          strb[i] = (i >= off) && (i < off + size);
          wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end
      end else begin
        sh = word >> (8 * off);
        if (size == 1)      rdata = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (size == 2) rdata = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else                rdata = sh;
      end
    end
  endfunction

  // Memory: accepts after cfg_rdy wait cycles, read data cfg_rv cycles after acceptance.
  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!rst) begin
        mm_busy    = 0;
        mm_rv_pend = 0;
      end else if (mm_rv_pend) begin
        if (mm_rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = cfg_word;
          mm_rv_pend = 0;
        end else mm_rv_cnt--;
      end else if (mem_req) begin
        if (!mm_busy) begin
          mm_busy    = 1;
          mm_rdy_cnt = cfg_rdy;
        end
        if (mm_rdy_cnt == 0) begin
          mem_ready = 1'b1;
          mm_busy   = 0;
          if (!mem_we) begin
            if (cfg_rv == 0) begin
              mem_rvalid = 1'b1;
              mem_rdata  = cfg_word;
            end else begin
              mm_rv_pend = 1;
              mm_rv_cnt  = cfg_rv - 1;
            end
          end
        end else mm_rdy_cnt--;
      end
    end
  end

  // Monitor: memory-side transactions and core-side completions.
  initial begin
    memtx_t m;
    resp_t  r;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) stall_cnt = 0;
      else begin
        if (mem_req) begin
          if (mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_unexpected actual=addr %h required=no request", mem_addr);
          end else begin
            m = mem_q[0];
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(m.strb));
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            if (mem_ready) void'(mem_q.pop_front());
          end
        end
        if ((cpu_read || cpu_write) && cpu_stall) stall_cnt++;
        else if (cpu_read || cpu_write) begin
          if (resp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=rdata %h err %0d required=no completion",
                     cpu_rdata, err_code);
          end else begin
            r = resp_q.pop_front();
            chk("cpu_rdata", cpu_rdata, r.rdata);
            chk("err_code", 32'(err_code), 32'(r.err));
            chk("stall_cycles", stall_cnt, r.stall);
          end
          stall_cnt = 0;
        end else begin
          chk("idle_stall", 32'(cpu_stall), 32'd0);
        end
        if (!(cpu_read || cpu_write) || cpu_stall) begin
          chk("rdata_outside_done", cpu_rdata, 32'd0);
          chk("err_outside_done", 32'(err_code), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input int rdy, input int rv, input logic [31:0] word);
    resp_t  r;
    memtx_t m;
    logic [1:0]  e;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [31:0] ewd;
    bit done;
    model(wr, addr, wd, f3, word, e, ed, es, ewd);
    r.err   = e;
    r.rdata = ed;
    r.stall = (e != 2'd0) ? 1 : 2 + rdy + (wr ? 0 : rv);
    if (e == 2'd0 && (1 + rdy + (wr ? 0 : rv)) > int'(TO)) begin
      r.err   = 2'd3;
      r.rdata = '0;
      r.stall = 1 + int'(TO);
    end
    resp_q.push_back(r);
    if (e == 2'd0) begin
      m.addr  = addr & ~32'd3;
      m.we    = wr;
      m.strb  = es;
      m.wdata = ewd;
      mem_q.push_back(m);
    end
    cfg_rdy   = rdy;
    cfg_rv    = rv;
    cfg_word  = word;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_func3 = f3;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!cpu_stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL completion_bound actual=still stalled required=done within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  f;
    int          k;
    memtx_t      m;
    rst       = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_func3 = '0;
    #3;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_err", 32'(err_code), 32'd0);
    chk("reset_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    issue(1, 0, 32'h0000_0103, 32'h0, 3'd0, 0, 0, 32'h80FF_1234);
    idle(1);
    issue(0, 1, 32'h0000_0202, 32'h0000_ABCD, 3'd1, 3, 0, 32'h0);
    idle(1);
    issue(1, 0, 32'h0000_0301, 32'h0, 3'd2, 0, 0, 32'h0);
    idle(1);
    issue(1, 0, 32'h0000_0300, 32'h0, 3'd5, 0, 0, 32'h0000_F00F);
    idle(1);
    issue(1, 0, 32'h0000_0040, 32'h0, 3'd3, 0, 0, 32'h0);
    idle(1);
    issue(0, 1, 32'h0000_0044, 32'h1234_5678, 3'd4, 0, 0, 32'h0);
    idle(1);

    // Read that never sees rvalid in time; the late rvalid lands in IDLE.
    issue(1, 0, 32'h0000_0080, 32'h0, 3'd2, 0, 20, 32'hDEAD_BEEF);
    idle(25);
    chk("late_rvalid_mem_req", 32'(mem_req), 32'd0);

    // Reset while waiting for read data.
    cfg_rdy   = 0;
    cfg_rv    = 1000;
    cfg_word  = 32'h5555_AAAA;
    m.addr    = 32'h0000_0020;
    m.we      = 1'b0;
    m.strb    = 4'h0;
    m.wdata   = 32'h0;
    mem_q.push_back(m);
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h0000_0020;
    cpu_func3 = 3'd2;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("wait_stall", 32'(cpu_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    resp_q.delete();
    mem_q.delete();
    cpu_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    issue(0, 1, 32'h0000_0010, 32'hCAFE_F00D, 3'd2, 0, 0, 32'h0);
    idle(1);

    // Back-to-back accesses with no idle cycle between them.
    issue(1, 0, 32'h0000_0011, 32'h0, 3'd4, 0, 1, 32'h0000_9C00);
    issue(0, 1, 32'h0000_0012, 32'h0000_00A5, 3'd0, 1, 0, 32'h0);
    idle(2);

    for (int n = 0; n < 250; n++) begin
      k = int'($urandom_range(0, 2));
      a = $urandom;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
      else if (k != 0)               f = 3'($urandom_range(0, 2));
      else begin
        f = 3'($urandom_range(0, 4));
        if (f == 3'd3) f = 3'd5;
      end
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(k != 1, k != 0, a, w, f, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(4);
    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("mem_queue_drained", mem_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
